modn_cascade_counter: RTL

- Synchronous, parametrised multi-digit mod-N counter: DIGITS cascaded digit cells, each counting modulo RADIX (default 10 → BCD decade).
- Next generation of our ripple decade counter:
  - single clock domain, no ripple clocks, no reset-by-decode glitch;
  - adds up/down, parallel load, synchronous clear, enable, terminal-count and wrap outputs.
- Used for timers, event counters and time-of-day style chains (e.g. RADIX=6/10 digits).

---
 rtl/modn_cascade_counter_pkg.sv | 18 +
 rtl/modn_cascade_counter_if.sv | 35 +++
 rtl/modn_cascade_counter_digit.sv | 67 ++++++
 rtl/modn_cascade_counter.sv | 77 +++++++
 4 files changed

// File: rtl/modn_cascade_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : modn_cascade_counter_pkg
// Brief    : Shared constants and helpers for the mod-N cascade counter.
// Revision : 1.0
// ============================================================================
package modn_cascade_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // A radix-2 digit still needs one storage bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : modn_cascade_counter_pkg
`default_nettype wire

// File: rtl/modn_cascade_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : modn_cascade_counter_if
// Brief    : Control/data bundle between a counter user and the counter.
// Revision : 1.0
// ============================================================================
interface modn_cascade_counter_if #(
    parameter int RADIX  = 10,
    parameter int DIGITS = 2
);
    import modn_cascade_counter_pkg::*;

    localparam int DW = clog2_min1(RADIX);

    logic                   en;
    logic                   up_dn;
    logic                   clr;
    logic                   load;
    logic [DIGITS*DW-1:0]   load_val;
    logic [DIGITS*DW-1:0]   q;
    logic                   tc;
    logic                   wrap;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output q, tc, wrap
    );

endinterface : modn_cascade_counter_if
`default_nettype wire

// File: rtl/modn_cascade_counter_digit.sv
`default_nettype none
// ============================================================================
// Module   : modn_digit
// Brief    : One mod-RADIX digit cell with clamped load and up/down step.
// Revision : 1.0
// ============================================================================
module modn_digit
    import modn_cascade_counter_pkg::*;
#(
    parameter int RADIX = 10,
    parameter int DW    = clog2_min1(RADIX)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          clr,
    input  wire logic          load,
    input  wire logic [DW-1:0] load_d,
    input  wire logic          step,
    input  wire logic          up_dn,
    output logic      [DW-1:0] d,
    output logic               at_max,
    output logic               at_zero
);

    localparam logic [DW-1:0] c_MAX = DW'(RADIX - 1);
    localparam logic [DW-1:0] c_ONE = DW'(1);

    logic [DW-1:0] r_d;
    logic [DW-1:0] w_load_d;
    logic [DW-1:0] w_next;

    // A power-of-two radix covers every encoding, so there is nothing to clamp.
    generate
        if (RADIX == (1 << DW)) begin : g_noclamp
            assign w_load_d = load_d;
        end else begin : g_clamp
            assign w_load_d = (load_d > c_MAX) ? c_MAX : load_d;
        end
    endgenerate

    always_comb begin
        w_next = r_d;
        if (up_dn == DIR_UP) begin
            w_next = (r_d == c_MAX) ? '0 : r_d + c_ONE;
        end else begin
            w_next = (r_d == '0) ? c_MAX : r_d - c_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d <= '0;
        end else if (clr) begin
            r_d <= '0;
        end else if (load) begin
            r_d <= w_load_d;
        end else if (step) begin
            r_d <= w_next;
        end
    end

    assign d       = r_d;
    assign at_max  = (r_d == c_MAX);
    assign at_zero = (r_d == '0);

endmodule : modn_digit
`default_nettype wire

// File: rtl/modn_cascade_counter.sv
`default_nettype none
// ============================================================================
// Module   : modn_cascade_counter
// Brief    : Synchronous DIGITS-wide chain of mod-RADIX digits, up/down/load.
// Revision : 1.0
// ============================================================================
module modn_cascade_counter
    import modn_cascade_counter_pkg::*;
#(
    parameter int RADIX  = 10,
    parameter int DIGITS = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    modn_cascade_counter_if.slave  bus
);

    localparam int DW = clog2_min1(RADIX);

    logic [DIGITS*DW-1:0] w_q;
    logic [DIGITS-1:0]    w_at_max;
    logic [DIGITS-1:0]    w_at_zero;
    logic [DIGITS-1:0]    w_step;
    logic [DIGITS:0]      w_chain;
    logic                 w_go;
    logic                 w_tc;
    logic                 r_wrap;

    assign w_go = bus.en & ~bus.clr & ~bus.load;

    // w_chain[i] is high when every digit below i sits at its rollover value.
    always_comb begin
        w_chain    = '0;
        w_chain[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_chain[i+1] = w_chain[i] &
                           ((bus.up_dn == DIR_UP) ? w_at_max[i] : w_at_zero[i]);
        end
    end

    assign w_step = {DIGITS{w_go}} & w_chain[DIGITS-1:0];
    assign w_tc   = w_go & w_chain[DIGITS];

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            modn_digit #(
                .RADIX (RADIX),
                .DW    (DW)
            ) u_digit (
                .clk     (clk),
                .rst     (rst),
                .clr     (bus.clr),
                .load    (bus.load),
                .load_d  (bus.load_val[i*DW +: DW]),
                .step    (w_step[i]),
                .up_dn   (bus.up_dn),
                .d       (w_q[i*DW +: DW]),
                .at_max  (w_at_max[i]),
                .at_zero (w_at_zero[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_tc;
        end
    end

    assign bus.q    = w_q;
    assign bus.tc   = w_tc;
    assign bus.wrap = r_wrap;

endmodule : modn_cascade_counter
`default_nettype wire
